// File: rtl/sine_duty_gen_if.sv
// Duty-sample channel between the sine DDS source and the PWM comparator.
// The master side drives the period strobe, the sample and its valid/overrun
// status. The slave side returns duty_ready.
interface sine_duty_gen_if;
  logic        period_start;
  logic [31:0] duty_out;
  logic        duty_valid;
  logic        duty_ready;
  logic        overrun;

  modport master (
    output period_start,
    output duty_out,
    output duty_valid,
    output overrun,
    input  duty_ready
  );

  modport slave (
    input  period_start,
    input  duty_out,
    input  duty_valid,
    input  overrun,
    output duty_ready
  );
endinterface

// File: rtl/sine_duty_gen.sv
// sine_duty_gen: DDS sine source that produces one PWM duty value per carrier period.
// A free-running carrier counter marks period boundaries. At each boundary the
// 32-bit phase accumulator is sampled and stepped. The sample is decoded from a
// quarter-wave table, scaled to 0..STEPS-1 ticks and offered over valid/ready.
// Optional build macro AMPLITUDE_SCALE_EN adds an amplitude input and one extra
// scaling stage, which raises the latency from 3 to 4 cycles.
module sine_duty_gen #(
  parameter int unsigned CLK_FREQUENCY = 33_330_000,
  parameter int unsigned PWM_FREQUENCY = 500_000,
  parameter int unsigned SAMPLE_WIDTH  = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [31:0]     phase_inc,
`ifdef AMPLITUDE_SCALE_EN
  input  logic [7:0]      amplitude,
`endif
  sine_duty_gen_if.master dout
);

  localparam int unsigned STEPS  = CLK_FREQUENCY / PWM_FREQUENCY;
  localparam int unsigned SW     = SAMPLE_WIDTH;
  localparam int unsigned CNT_W  = $clog2(STEPS);
  localparam int unsigned PROD_W = SW + $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
  localparam logic [SW-1:0]    HALF     = {1'b1, {(SW-1){1'b0}}};
  // Mid-scale duty: (2^(SW-1) * STEPS) >> SW
  localparam logic [31:0] DUTY_RST = 32'((64'(STEPS) << (SW - 1)) >> SW);

  // Quarter-wave table round(2047*sin(pi/2*i/64)), i = 0..64. The values are for 12-bit samples.
  function automatic logic [10:0] quarter_sine(input logic [6:0] idx);
    logic [10:0] v;
    v = 11'd0;
    case (idx)
      7'd0:  v = 11'd0;    7'd1:  v = 11'd50;   7'd2:  v = 11'd100;  7'd3:  v = 11'd151;
      7'd4:  v = 11'd201;  7'd5:  v = 11'd251;  7'd6:  v = 11'd300;  7'd7:  v = 11'd350;
      7'd8:  v = 11'd399;  7'd9:  v = 11'd449;  7'd10: v = 11'd497;  7'd11: v = 11'd546;
      7'd12: v = 11'd594;  7'd13: v = 11'd642;  7'd14: v = 11'd690;  7'd15: v = 11'd737;
      7'd16: v = 11'd783;  7'd17: v = 11'd830;  7'd18: v = 11'd875;  7'd19: v = 11'd920;
      7'd20: v = 11'd965;  7'd21: v = 11'd1009; 7'd22: v = 11'd1052; 7'd23: v = 11'd1095;
      7'd24: v = 11'd1137; 7'd25: v = 11'd1179; 7'd26: v = 11'd1219; 7'd27: v = 11'd1259;
      7'd28: v = 11'd1299; 7'd29: v = 11'd1337; 7'd30: v = 11'd1375; 7'd31: v = 11'd1411;
      7'd32: v = 11'd1447; 7'd33: v = 11'd1483; 7'd34: v = 11'd1517; 7'd35: v = 11'd1550;
      7'd36: v = 11'd1582; 7'd37: v = 11'd1614; 7'd38: v = 11'd1644; 7'd39: v = 11'd1674;
      7'd40: v = 11'd1702; 7'd41: v = 11'd1729; 7'd42: v = 11'd1756; 7'd43: v = 11'd1781;
      7'd44: v = 11'd1805; 7'd45: v = 11'd1828; 7'd46: v = 11'd1850; 7'd47: v = 11'd1871;
      7'd48: v = 11'd1891; 7'd49: v = 11'd1910; 7'd50: v = 11'd1927; 7'd51: v = 11'd1944;
      7'd52: v = 11'd1959; 7'd53: v = 11'd1973; 7'd54: v = 11'd1986; 7'd55: v = 11'd1997;
      7'd56: v = 11'd2008; 7'd57: v = 11'd2017; 7'd58: v = 11'd2025; 7'd59: v = 11'd2032;
      7'd60: v = 11'd2037; 7'd61: v = 11'd2041; 7'd62: v = 11'd2045; 7'd63: v = 11'd2046;
      7'd64: v = 11'd2047;
      default: v = 11'd0;
    endcase
    return v;
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       phase_acc_q, phase_acc_d;
  logic              strobe;

  logic [SW-1:0]     s_q, s_d;
  logic              s_vld_q, s_vld_d;
`ifdef AMPLITUDE_SCALE_EN
  logic [7:0]        amp_q, amp_d;
  logic [SW-1:0]     sa_q, sa_d;
  logic              sa_vld_q, sa_vld_d;
  logic signed [SW+8:0] amp_prod;
`endif
  logic [SW-1:0]     u;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;

  logic [31:0]       duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;
  logic              overrun_q, overrun_d;

  logic [1:0]        quad;
  logic [5:0]        addr;
  logic [6:0]        idx;
  logic [10:0]       mag;

  // Carrier counter, period strobe and phase accumulator step
  always_comb begin
    cnt_d       = cnt_q;
    phase_acc_d = phase_acc_q;
    strobe      = enable && (cnt_q == LAST_CNT) && !reset;
    if (enable) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
    if (strobe) begin
      phase_acc_d = phase_acc_q + phase_inc;
    end
  end

  // Boundary stage: sample the pre-step phase and decode it through the quarter table
  always_comb begin
    quad    = phase_acc_q[31:30];
    addr    = phase_acc_q[29:24];
    idx     = quad[0] ? (7'd64 - {1'b0, addr}) : {1'b0, addr};
    mag     = quarter_sine(idx);
    s_d     = s_q;
    s_vld_d = strobe;
    if (strobe) begin
      s_d = quad[1] ? SW'(~{1'b0, mag} + 1'b1) : SW'({1'b0, mag});
    end
  end

`ifdef AMPLITUDE_SCALE_EN
  // Amplitude stage: signed scale by amplitude/256 with arithmetic shift
  always_comb begin
    amp_d    = strobe ? amplitude : amp_q;
    amp_prod = $signed(s_q) * $signed({1'b0, amp_q});
    sa_d     = s_vld_q ? SW'(amp_prod >>> 8) : sa_q;
    sa_vld_d = s_vld_q;
  end
`endif

  // Scale stage: offset to unsigned, then multiply by STEPS at full width.
  // Adding HALF modulo 2^SW maps -2047..2047 onto 1..4095.
  always_comb begin
`ifdef AMPLITUDE_SCALE_EN
    u          = sa_q + HALF;
    prod_vld_d = sa_vld_q;
`else
    u          = s_q + HALF;
    prod_vld_d = s_vld_q;
`endif
    prod_d = prod_vld_d ? (PROD_W'(u) * PROD_W'(STEPS)) : prod_q;
  end

  // Output register and valid/ready handshake with sticky overrun
  always_comb begin
    duty_d       = duty_q;
    duty_valid_d = duty_valid_q;
    overrun_d    = overrun_q;
    if (duty_valid_q && dout.duty_ready) begin
      duty_valid_d = 1'b0;
    end
    if (prod_vld_q) begin
      duty_d       = 32'(prod_q >> SW);
      duty_valid_d = 1'b1;
      if (duty_valid_q && !dout.duty_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset also flushes in-flight samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      phase_acc_q  <= '0;
      s_q          <= '0;
      s_vld_q      <= 1'b0;
`ifdef AMPLITUDE_SCALE_EN
      amp_q        <= '0;
      sa_q         <= '0;
      sa_vld_q     <= 1'b0;
`endif
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      duty_q       <= DUTY_RST;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      phase_acc_q  <= phase_acc_d;
      s_q          <= s_d;
      s_vld_q      <= s_vld_d;
`ifdef AMPLITUDE_SCALE_EN
      amp_q        <= amp_d;
      sa_q         <= sa_d;
      sa_vld_q     <= sa_vld_d;
`endif
      prod_q       <= prod_d;
      prod_vld_q   <= prod_vld_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout.period_start = strobe;
  assign dout.duty_out     = duty_q;
  assign dout.duty_valid   = duty_valid_q;
  assign dout.overrun      = overrun_q;

endmodule

// File: tb/tb_sine_duty_gen.sv
// Testbench for sine_duty_gen. A reference model predicts the period strobes
// and the duty samples, and queues each expected sample with its landing cycle.
// A monitor pops the queue and compares the sample when it appears on the DUT
// outputs. It also compares strobe, valid and overrun whenever they change.
module tb_sine_duty_gen;
  localparam int STEPS = 33_330_000 / 500_000;
`ifdef AMPLITUDE_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] phase_inc;
`ifdef AMPLITUDE_SCALE_EN
  logic [7:0]  amplitude;
`endif

  sine_duty_gen_if dif();

  sine_duty_gen #(
    .CLK_FREQUENCY(33_330_000),
    .PWM_FREQUENCY(500_000),
    .SAMPLE_WIDTH(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .phase_inc(phase_inc),
`ifdef AMPLITUDE_SCALE_EN
    .amplitude(amplitude),
`endif
    .dout(dif)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  exp_t sb[$];
  int   land[$];
  int   m_cnt = 0;
  logic [31:0] m_phase = '0;
  bit   m_valid = 1'b0;
  bit   m_ovr = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  function automatic int quarter(input int i);
    return int'($floor(2047.0 * $sin(PI / 2.0 * real'(i) / 64.0) + 0.5));
  endfunction

  function automatic int amp_now();
`ifdef AMPLITUDE_SCALE_EN
    return int'(amplitude);
`else
    return 256;
`endif
  endfunction

  // Sine value from the phase quadrant, amplitude scale, then ticks in 0..STEPS-1.
  function automatic int expect_duty(input logic [31:0] ph, input int amp);
    int q;
    int a;
    int s;
    q = int'(ph[31:30]);
    a = int'(ph[29:24]);
    case (q)
      0:       s = quarter(a);
      1:       s = quarter(64 - a);
      2:       s = -quarter(a);
      default: s = -quarter(64 - a);
    endcase
    s = (s * amp) >>> 8;
    return ((s + 2048) * STEPS) >>> 12;
  endfunction

  // Reference model: carrier, phase and handshake state after each rising edge
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_cnt   = 0;
      m_phase = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      land.delete();
      sb.delete();
    end else begin
      if (land.size() > 0 && land[0] == cyc) begin
        void'(land.pop_front());
        if (m_valid && !dif.duty_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid && dif.duty_ready) begin
        m_valid = 1'b0;
      end
      if (enable && m_cnt == STEPS - 1) begin
        sb.push_back('{val: expect_duty(m_phase, amp_now()), due: cyc + LAT - 1});
        land.push_back(cyc + LAT - 1);
        m_phase = m_phase + phase_inc;
      end
      if (enable) m_cnt = (m_cnt == STEPS - 1) ? 0 : m_cnt + 1;
    end
  end

  bit prev_dv = 1'b0, prev_mv = 1'b0, prev_ov = 1'b0, prev_mo = 1'b0;
  bit exp_ps;
  exp_t it;

  // Monitor: samples DUT outputs on the falling edge
  always @(negedge clk) begin
    if (started) begin
      exp_ps = !reset && enable && (m_cnt == STEPS - 1);
      if (exp_ps || dif.period_start) check("period_start", longint'(dif.period_start), longint'(exp_ps));
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        check("duty_out", longint'(dif.duty_out), longint'(it.val));
        check("valid_on_land", longint'(dif.duty_valid), 1);
      end
      if (dif.duty_valid != prev_dv || m_valid != prev_mv)
        check("duty_valid", longint'(dif.duty_valid), longint'(m_valid));
      if (dif.overrun != prev_ov || m_ovr != prev_mo)
        check("overrun", longint'(dif.overrun), longint'(m_ovr));
      prev_dv = dif.duty_valid;
      prev_mv = m_valid;
      prev_ov = dif.overrun;
      prev_mo = m_ovr;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves time just after the edge that precedes the edge where a sample lands.
  task automatic wait_pre_land();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (land.size() > 0 && land[0] == cyc + 1) found = 1'b1;
    end
    if (!found) check("wait_land_timeout", 0, 1);
  endtask

  task automatic wait_strobe();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (dif.period_start) found = 1'b1;
    end
    if (!found) check("wait_strobe_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    phase_inc      = '0;
    dif.duty_ready = 1'b1;
`ifdef AMPLITUDE_SCALE_EN
    amplitude      = 8'd128;
`endif
    step(3);
    check("rst_duty_out", longint'(dif.duty_out), 33);
    check("rst_duty_valid", longint'(dif.duty_valid), 0);
    check("rst_overrun", longint'(dif.overrun), 0);
    check("rst_period_start", longint'(dif.period_start), 0);
    reset = 1'b0;
    step(70);

    // Quarter-turn steps visit every quadrant boundary
    phase_inc = 32'h4000_0000;
    step(5 * STEPS);

    // Full sine sweep of 256 periods, with the phase wrapping at the end
    phase_inc = 32'h0100_0000;
    step(256 * STEPS);

    // Handshake corner cases
    phase_inc = 32'h0340_0000;
    dif.duty_ready = 1'b0;
    wait_pre_land();
    step(1);
    wait_pre_land();
    dif.duty_ready = 1'b1;
    step(1);
    dif.duty_ready = 1'b0;
    wait_pre_land();
    step(1);
    wait_pre_land();
    step(2);
    check("overrun_set", longint'(dif.overrun), 1);
    wait_pre_land();
    dif.duty_ready = 1'b1;
    step(1);
    dif.duty_ready = 1'b0;
    step(2);
    check("coincident_valid", longint'(dif.duty_valid), 1);
    dif.duty_ready = 1'b1;
    step(5);

    // Freeze in mid-period, then resume from the held count
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    phase_inc = 32'h0520_0000;
    step(STEPS + 20);
    enable = 1'b0;
    step(200);
    enable = 1'b1;
    step(3 * STEPS);

    // Randomized segments
    for (int seg = 0; seg < 16; seg++) begin
      phase_inc = $urandom();
`ifdef AMPLITUDE_SCALE_EN
      amplitude = 8'($urandom_range(0, 255));
`endif
      for (int k = 0, len = int'($urandom_range(80, 400)); k < len; k++) begin
        dif.duty_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) enable = !enable;
        step(1);
      end
      enable = 1'b1;
    end
    dif.duty_ready = 1'b1;
    step(2 * STEPS);

    // A reset one cycle after a strobe flushes the in-flight sample
    wait_strobe();
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);
    check("flush_no_valid", longint'(dif.duty_valid), 0);
    check("flush_duty_out", longint'(dif.duty_out), 33);

    enable = 1'b0;
    step(LAT + 3);
    check("sb_drained", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
